multicycle_main_fsm: RTL and testbench

//  Main control FSM for the multicycle ARM datapath; successor to the single-cycle main decoder.

---
 rtl/multicycle_main_fsm.sv | 130 +++++++++++++
 tb/tb_multicycle_main_fsm.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm: multicycle ARM main control FSM with optional memory wait-state handshake,
// undefined-op flag and retired-instruction counter.
module multicycle_main_fsm #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             MemReady,
    output logic             IRWrite,
    output logic             NextPC,
    output logic             AdrSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             ALUOp,
    output logic             Branch,
    output logic             RegW,
    output logic             MemW,
    output logic             Undef,
    output logic             InstrDone,
    output logic [CNT_W-1:0] InstrCount,
    output logic [3:0]       State
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t st;
    logic   ready;
    logic   unused_funct;

    assign ready        = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;
    assign unused_funct = ^Funct[4:1];
    assign State        = st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= FETCH;
            InstrCount <= '0;
        end else begin
            if (InstrDone)
                InstrCount <= InstrCount + CNT_W'(1);
            case (st)
                FETCH:   st <= ready ? DECODE : FETCH;
                DECODE:  st <= (Op == 2'b01) ? MEMADR :
                               (Op == 2'b10) ? BRANCH :
                               (Op == 2'b11) ? FETCH  :
                               Funct[5]      ? EXECI  : EXECR;
                MEMADR:  st <= Funct[0] ? MEMRD : MEMWR;
                MEMRD:   st <= ready ? MEMWB : MEMRD;
                MEMWR:   st <= ready ? FETCH : MEMWR;
                EXECR:   st <= ALUWB;
                EXECI:   st <= ALUWB;
                default: st <= FETCH;
            endcase
        end
    end

    // Moore decode of the state register; only fetch strobes, Undef and InstrDone look at inputs
    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 1'b0;
        Branch    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Undef     = 1'b0;
        InstrDone = 1'b0;
        case (st)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = ready & ~reset;
                NextPC    = ready & ~reset;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                Undef     = (Op == 2'b11);
                InstrDone = (Op == 2'b11);
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
                InstrDone = 1'b1;
            end
            MEMWR: begin
                AdrSrc    = 1'b1;
                MemW      = 1'b1;
                InstrDone = ready;
            end
            EXECR:  ALUOp = 1'b1;
            EXECI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            ALUWB: begin
                RegW      = 1'b1;
                InstrDone = 1'b1;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
                InstrDone = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb_multicycle_main_fsm: directed checks of the multicycle main FSM, with handshake (a)
// and without handshake using a 4-bit counter (b).
module tb_multicycle_main_fsm;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  Op = 2'b00;
    logic [5:0]  Funct = 6'b0;
    logic        MemReady = 1'b1;

    logic        a_irw, a_npc, a_adr, a_srca, a_br, a_op, a_regw, a_memw, a_undef, a_done;
    logic [1:0]  a_srcb, a_res;
    logic [31:0] a_cnt;
    logic [3:0]  a_st;

    logic        b_irw, b_npc, b_adr, b_srca, b_br, b_op, b_regw, b_memw, b_undef, b_done;
    logic [1:0]  b_srcb, b_res;
    logic [3:0]  b_cnt;
    logic [3:0]  b_st;

    int checks = 0;
    int errors = 0;
    int irw_pulses = 0;

    always #5 clk = ~clk;

    multicycle_main_fsm #(.MEM_HANDSHAKE(1), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
        .IRWrite(a_irw), .NextPC(a_npc), .AdrSrc(a_adr), .ALUSrcA(a_srca), .ALUSrcB(a_srcb),
        .ResultSrc(a_res), .ALUOp(a_op), .Branch(a_br), .RegW(a_regw), .MemW(a_memw),
        .Undef(a_undef), .InstrDone(a_done), .InstrCount(a_cnt), .State(a_st)
    );

    multicycle_main_fsm #(.MEM_HANDSHAKE(0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
        .IRWrite(b_irw), .NextPC(b_npc), .AdrSrc(b_adr), .ALUSrcA(b_srca), .ALUSrcB(b_srcb),
        .ResultSrc(b_res), .ALUOp(b_op), .Branch(b_br), .RegW(b_regw), .MemW(b_memw),
        .Undef(b_undef), .InstrDone(b_done), .InstrCount(b_cnt), .State(b_st)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // samples IRWrite of dut_a just before the edge, then lands 1 time unit after it
    task automatic tick();
        #3;
        irw_pulses += int'(a_irw);
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk("rst_state", 32'(a_st), 32'd0);
        chk("rst_irw", 32'(a_irw), 32'd0);
        chk("rst_npc", 32'(a_npc), 32'd0);
        chk("rst_cnt", a_cnt, 32'd0);
        reset = 1'b0;
        #1;
        // ADD register
        chk("add_s0", 32'(a_st), 32'd0);
        chk("add_irw", 32'(a_irw), 32'd1);
        chk("add_npc", 32'(a_npc), 32'd1);
        chk("add_fetch_srcb", 32'(a_srcb), 32'd2);
        tick();
        chk("add_s1", 32'(a_st), 32'd1);
        chk("add_s1_regw", 32'(a_regw), 32'd0);
        tick();
        chk("add_s6", 32'(a_st), 32'd6);
        chk("add_s6_aluop", 32'(a_op), 32'd1);
        chk("add_s6_regw", 32'(a_regw), 32'd0);
        tick();
        chk("add_s8", 32'(a_st), 32'd8);
        chk("add_s8_regw", 32'(a_regw), 32'd1);
        chk("add_s8_done", 32'(a_done), 32'd1);
        tick();
        chk("add_back", 32'(a_st), 32'd0);
        chk("add_cnt", a_cnt, 32'd1);
        // LDR with 3 fetch waits and 2 memread waits
        Op = 2'b01;
        Funct = 6'b011001;
        MemReady = 1'b0;
        irw_pulses = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("ldr_wait_st", 32'(a_st), 32'd0);
            chk("ldr_wait_irw", 32'(a_irw), 32'd0);
            tick();
        end
        MemReady = 1'b1;
        #1;
        chk("ldr_fetch_irw", 32'(a_irw), 32'd1);
        tick();
        chk("ldr_s1", 32'(a_st), 32'd1);
        tick();
        chk("ldr_s2", 32'(a_st), 32'd2);
        chk("ldr_s2_srcb", 32'(a_srcb), 32'd1);
        MemReady = 1'b0;
        tick();
        Op = 2'b11;
        for (int i = 0; i < 2; i++) begin
            chk("ldr_s3", 32'(a_st), 32'd3);
            chk("ldr_s3_adr", 32'(a_adr), 32'd1);
            tick();
        end
        MemReady = 1'b1;
        #1;
        chk("ldr_s3_go", 32'(a_st), 32'd3);
        tick();
        chk("ldr_s4", 32'(a_st), 32'd4);
        chk("ldr_s4_regw", 32'(a_regw), 32'd1);
        chk("ldr_s4_res", 32'(a_res), 32'd1);
        chk("ldr_s4_done", 32'(a_done), 32'd1);
        tick();
        chk("ldr_back", 32'(a_st), 32'd0);
        chk("ldr_cnt", a_cnt, 32'd2);
        chk("ldr_irw_pulses", 32'(irw_pulses), 32'd1);
        // STR, one wait in MEMWR
        Op = 2'b01;
        Funct = 6'b011000;
        tick();
        chk("str_s1", 32'(a_st), 32'd1);
        tick();
        chk("str_s2", 32'(a_st), 32'd2);
        chk("str_s2_memw", 32'(a_memw), 32'd0);
        MemReady = 1'b0;
        tick();
        chk("str_s5", 32'(a_st), 32'd5);
        chk("str_s5_memw_wait", 32'(a_memw), 32'd1);
        chk("str_s5_done_wait", 32'(a_done), 32'd0);
        chk("str_s5_regw", 32'(a_regw), 32'd0);
        tick();
        MemReady = 1'b1;
        #1;
        chk("str_s5_memw", 32'(a_memw), 32'd1);
        chk("str_s5_done", 32'(a_done), 32'd1);
        tick();
        chk("str_back", 32'(a_st), 32'd0);
        chk("str_cnt", a_cnt, 32'd3);
        // Branch
        Op = 2'b10;
        tick();
        chk("b_s1", 32'(a_st), 32'd1);
        tick();
        chk("b_s9", 32'(a_st), 32'd9);
        chk("b_s9_branch", 32'(a_br), 32'd1);
        chk("b_s9_done", 32'(a_done), 32'd1);
        tick();
        chk("b_back", 32'(a_st), 32'd0);
        chk("b_cnt", a_cnt, 32'd4);
        // Undefined op
        Op = 2'b11;
        tick();
        chk("u_s1", 32'(a_st), 32'd1);
        chk("u_undef", 32'(a_undef), 32'd1);
        chk("u_done", 32'(a_done), 32'd1);
        tick();
        chk("u_back", 32'(a_st), 32'd0);
        chk("u_undef_off", 32'(a_undef), 32'd0);
        chk("u_cnt", a_cnt, 32'd5);
        // Reset in the middle of a stalled store
        Op = 2'b01;
        Funct = 6'b011000;
        tick();
        tick();
        MemReady = 1'b0;
        tick();
        chk("mid_s5", 32'(a_st), 32'd5);
        reset = 1'b1;
        #1;
        chk("mid_rst_state", 32'(a_st), 32'd0);
        chk("mid_rst_memw", 32'(a_memw), 32'd0);
        tick();
        reset = 1'b0;
        Op = 2'b00;
        Funct = 6'b0;
        #1;
        chk("mid_rst_cnt", a_cnt, 32'd0);
        chk("mid_a_stall_irw", 32'(a_irw), 32'd0);
        // No handshake, 4-bit counter, MemReady held low
        chk("nohs_s0", 32'(b_st), 32'd0);
        chk("nohs_irw", 32'(b_irw), 32'd1);
        tick();
        chk("nohs_s1", 32'(b_st), 32'd1);
        tick();
        chk("nohs_s6", 32'(b_st), 32'd6);
        tick();
        chk("nohs_s8", 32'(b_st), 32'd8);
        chk("nohs_s8_regw", 32'(b_regw), 32'd1);
        tick();
        chk("nohs_cnt1", 32'(b_cnt), 32'd1);
        for (int i = 0; i < 14 * 4; i++) tick();
        chk("nohs_cnt15", 32'(b_cnt), 32'd15);
        for (int i = 0; i < 4; i++) tick();
        chk("nohs_wrap", 32'(b_cnt), 32'd0);
        chk("nohs_wrap_st", 32'(b_st), 32'd0);
        chk("a_still_fetch", 32'(a_st), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
